// File: rtl/fpu_arb_pkg.sv
// Shared types and round-robin pick helper for the FPU request arbiter.
// Optional build macro FPU_ARB_PRIO0_EN is handled in fpu_rr_arbiter.
package fpu_arb_pkg;

    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned ID_W    = 5;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HELD
    } fsm_state_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    // One-hot grant of the first set bit of req searching from ptr+1, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [ID_W-1:0]    ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k <= n && !found && req[idx[ID_W-1:0]]) begin
                gnt[idx[ID_W-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Requester / FPU handshake bundle for fpu_req_arbiter; slave is the arbiter side.
interface fpu_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_OP  = 1
);
    logic [NUM_REQ-1:0]              i_req_valid;
    logic [NUM_REQ-1:0]              o_req_ready;
    logic [NUM_REQ-1:0][NUM_OP-1:0]  i_req_op;
    logic [NUM_REQ-1:0][31:0]        i_req_a;
    logic [NUM_REQ-1:0][31:0]        i_req_b;
    logic                            i_hold;
    logic                            o_fpu_valid;
    logic [NUM_OP-1:0]               o_fpu_op;
    logic [31:0]                     o_fpu_a;
    logic [31:0]                     o_fpu_b;
    logic [31:0]                     i_fpu_result;
    logic [NUM_REQ-1:0]              o_rsp_valid;
    logic [31:0]                     o_rsp_result;
    logic                            o_busy;
    logic                            o_held;

    modport slave (
        input  i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_result,
        output o_req_ready, o_fpu_valid, o_fpu_op, o_fpu_a, o_fpu_b,
               o_rsp_valid, o_rsp_result, o_busy, o_held
    );

    modport master (
        output i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_result,
        input  o_req_ready, o_fpu_valid, o_fpu_op, o_fpu_a, o_fpu_b,
               o_rsp_valid, o_rsp_result, o_busy, o_held
    );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Round-robin request picker with pointer register, updated on handshake only.
// FPU_ARB_PRIO0_EN: requester 0 wins whenever valid and does not move the pointer.
module fpu_rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);
    localparam int unsigned RW = $clog2(NUM_REQ);

    logic [ID_W-1:0]    ptr_q;
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    // Bits of pick above NUM_REQ are always zero.
    assign unused_pick = ^pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, ptr_q, NUM_REQ);
`ifdef FPU_ARB_PRIO0_EN
        if (req[0]) begin
            pick = MAX_REQ'(1);
        end
`endif
        grant = en ? pick[NUM_REQ-1:0] : '0;
    end

    always_comb begin
        grant_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[RW'(i)]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (|grant) begin
`ifdef FPU_ARB_PRIO0_EN
            if (!grant[0]) begin
                ptr_q <= grant_id;
            end
`else
            ptr_q <= grant_id;
`endif
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one fixed-latency FPU between NUM_REQ requesters: RR grant, issue regs,
// tag pipe routing results back, hold/drain FSM. Honours FPU_ARB_PRIO0_EN (see fpu_rr_arbiter).
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_OP  = 1,
    parameter int unsigned FPU_LAT = 2
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fpu_req_arbiter_if.slave bus
);
    localparam int unsigned RW = $clog2(NUM_REQ);
    localparam int unsigned LW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

    fsm_state_e         state_q, state_d;
    logic               grant_en;
    logic               held;
    logic               drained;
    logic               pipe_busy;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_OP-1:0]  sel_op;
    logic [31:0]        sel_a, sel_b;
    logic               fpu_valid_q;
    logic [NUM_OP-1:0]  fpu_op_q;
    logic [31:0]        fpu_a_q, fpu_b_q;
    tag_t               issue_tag_q;
    tag_t [FPU_LAT-1:0] pipe_q;
    logic [NUM_REQ-1:0] rsp_onehot;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [31:0]        rsp_result_q;

    fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .req      (bus.i_req_valid),
        .en       (grant_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[RW'(i)]) begin
                sel_op = bus.i_req_op[RW'(i)];
                sel_a  = bus.i_req_a[RW'(i)];
                sel_b  = bus.i_req_b[RW'(i)];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fpu_valid_q <= 1'b0;
            fpu_op_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            issue_tag_q <= '0;
        end else begin
            fpu_valid_q     <= |grant;
            issue_tag_q.vld <= |grant;
            issue_tag_q.id  <= grant_id;
            if (|grant) begin
                fpu_op_q <= sel_op;
                fpu_a_q  <= sel_a;
                fpu_b_q  <= sel_b;
            end
        end
    end

    // Tag for an issue in cycle t+1 reaches the last stage in t+1+FPU_LAT, alongside its result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= issue_tag_q;
            for (int unsigned i = 1; i < FPU_LAT; i++) begin
                pipe_q[LW'(i)] <= pipe_q[LW'(i - 1)];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < FPU_LAT; i++) begin
            pipe_busy = pipe_busy | pipe_q[LW'(i)].vld;
        end
        rsp_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_onehot[RW'(i)] = pipe_q[FPU_LAT-1].vld && (pipe_q[FPU_LAT-1].id == ID_W'(i));
        end
        drained = !fpu_valid_q && !pipe_busy;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= rsp_onehot;
            if (pipe_q[FPU_LAT-1].vld) begin
                rsp_result_q <= bus.i_fpu_result;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.i_hold) state_d = DRAIN;
            DRAIN:   if (!bus.i_hold) state_d = RUN;
                     else if (drained) state_d = HELD;
            HELD:    if (!bus.i_hold) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Reset gating keeps ready low while reset is asserted, whatever the requesters drive.
    always_comb begin
        grant_en = (state_q == RUN) && !bus.i_hold && i_rst_n;
        held     = (state_q == HELD);
    end

    assign bus.o_req_ready  = grant;
    assign bus.o_fpu_valid  = fpu_valid_q;
    assign bus.o_fpu_op     = fpu_op_q;
    assign bus.o_fpu_a      = fpu_a_q;
    assign bus.o_fpu_b      = fpu_b_q;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_result = rsp_result_q;
    assign bus.o_busy       = pipe_busy | fpu_valid_q | (|rsp_valid_q);
    assign bus.o_held       = held;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Self-checking bench for fpu_req_arbiter: directed steps plus random traffic/hold
// against a transaction-level scoreboard model.
module tb_fpu_req_arbiter;
    localparam int N   = 4;
    localparam int OPW = 1;
    localparam int LAT = 2;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpu_req_arbiter_if #(.NUM_REQ(N), .NUM_OP(OPW)) bus ();

    fpu_req_arbiter #(.NUM_REQ(N), .NUM_OP(OPW), .FPU_LAT(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [31:0] fpu_fn(input logic [OPW-1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        return (op != '0) ? a - b : a + b;
    endfunction

    // Stub FPU: fixed LAT-cycle pipeline of fpu_fn
    logic [LAT*32-1:0] fpu_sr;
    always @(posedge clk)
        fpu_sr <= (fpu_sr << 32) | (LAT*32)'(fpu_fn(bus.o_fpu_op, bus.o_fpu_a, bus.o_fpu_b));
    assign bus.i_fpu_result = fpu_sr[LAT*32-1 -: 32];

    exp_t         sb[$];
    int           hist[$];
    int           cyc, ptr, held_from;
    int           n_cmp, n_err;
    logic         hold_prev, last_hs;
    logic [OPW-1:0] last_op;
    logic [31:0]  last_a, last_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        logic [N-1:0] s;
        int i;
`ifdef FPU_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            i = (ptr + k) % N;
            s = v >> i;
            if (s[0]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic h, input bit fix);
        logic [N*32-1:0]  av, bv;
        logic [N*OPW-1:0] ov;
        logic [N-1:0]     exp_rdy;
        logic             exp_held;
        logic [OPW-1:0]   eo;
        logic [31:0]      ea, eb;
        int               g;
        @(negedge clk);
        cyc++;
        av = '0; bv = '0; ov = '0;
        for (int i = 0; i < N; i++) begin
            av = (av << 32) | (N*32)'(fix ? 32'h3F80_0000 : $urandom());
            bv = (bv << 32) | (N*32)'(fix ? 32'h4000_0000 : $urandom());
            ov = (ov << OPW) | (N*OPW)'(fix ? 32'd0 : $urandom());
        end
        bus.i_req_valid = v;
        bus.i_hold      = h;
        bus.i_req_a     = av;
        bus.i_req_b     = bv;
        bus.i_req_op    = ov;
        // Held once the last outstanding response has been delivered, never sooner than 2 cycles after hold rises
        if (h && !hold_prev) begin
            held_from = cyc + 2;
            if (sb.size() != 0 && sb[$].due + 1 > held_from) held_from = sb[$].due + 1;
        end
        exp_held = hold_prev && (cyc >= held_from);
        g        = (h || hold_prev) ? -1 : model_pick(v);
        exp_rdy  = (g < 0) ? '0 : (N'(1) << g);
        #1;
        chk("ready", 32'(bus.o_req_ready), 32'(exp_rdy));
        chk("held", 32'(bus.o_held), 32'(exp_held));
        chk("busy", 32'(bus.o_busy), 32'(sb.size() != 0));
        chk("fpu_valid", 32'(bus.o_fpu_valid), 32'(last_hs));
        chk("fpu_op", 32'(bus.o_fpu_op), 32'(last_op));
        chk("fpu_a", bus.o_fpu_a, last_a);
        chk("fpu_b", bus.o_fpu_b, last_b);
        if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(N'(1) << sb[0].id));
            chk("rsp_result", bus.o_rsp_result, sb[0].res);
            void'(sb.pop_front());
        end else begin
            chk("rsp_idle", 32'(bus.o_rsp_valid), 32'd0);
        end
        last_hs = (g >= 0);
        if (g >= 0) begin
            eo = OPW'(ov >> (OPW * g));
            ea = 32'(av >> (32 * g));
            eb = 32'(bv >> (32 * g));
            last_op = eo; last_a = ea; last_b = eb;
            sb.push_back('{id: g, res: fpu_fn(eo, ea, eb), due: cyc + LAT + 2});
            hist.push_back(g);
`ifdef FPU_ARB_PRIO0_EN
            if (g != 0) ptr = g;
`else
            ptr = g;
`endif
        end
        hold_prev = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_req_valid = '0;
        bus.i_hold      = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_fpu_valid", 32'(bus.o_fpu_valid), 32'd0);
        chk("rst_fpu_op", 32'(bus.o_fpu_op), 32'd0);
        chk("rst_fpu_a", bus.o_fpu_a, 32'd0);
        chk("rst_fpu_b", bus.o_fpu_b, 32'd0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.o_rsp_result, 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_held", 32'(bus.o_held), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        ptr       = N - 1;
        last_hs   = 1'b0;
        last_op   = '0;
        last_a    = '0;
        last_b    = '0;
        hold_prev = 1'b0;
        held_from = 0;
    endtask

    initial begin
        logic h;
        int   c, expc;
        n_cmp = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0;
        bus.i_req_valid = '0;
        bus.i_hold      = 1'b0;
        bus.i_req_op    = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        do_reset();

        // Fairness from reset pointer: all requesters valid for 16 cycles
        hist.delete();
        for (int i = 0; i < 16; i++) step('1, 1'b0, 1'b0);
        for (int r = 0; r < N; r++) begin
            c = 0;
            foreach (hist[j]) if (hist[j] == r) c++;
`ifdef FPU_ARB_PRIO0_EN
            expc = (r == 0) ? 16 : 0;
`else
            expc = 4;
`endif
            chk($sformatf("fair_cnt%0d", r), 32'(c), 32'(expc));
        end
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Single request from requester 1 with fixed operands
        step(4'b0010, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Sparse: req2, gap, req0, then all valid to expose the pointer
        step(4'b0100, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Hold with three ops in flight, then release
        for (int i = 0; i < 3; i++) step('1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step('1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step('1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Requesters 0 and 3 continuously valid
        for (int i = 0; i < 8; i++) step(4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Random traffic with occasional hold episodes
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) h = ~h;
            step(N'($urandom()), h, 1'b0);
        end
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        // Reset with ops in flight; nothing stale may come out afterwards
        step('1, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step('0, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
